// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO controller driving an external 1-cycle-latency RAM, with Gray-coded pointer outputs.
// Optional registered almost_full is enabled by defining GRAY_FIFO_CTRL_ALMOST_FULL_EN.
module gray_fifo_ctrl #(
    parameter int AddrWidth        = 4,
    parameter int AlmostFullThresh = 2**AddrWidth - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_waddr,
    output logic                 mem_re,
    output logic [AddrWidth-1:0] mem_raddr,
    output logic [AddrWidth:0]   wr_ptr_gray,
    output logic [AddrWidth:0]   rd_ptr_gray,
    output logic [AddrWidth:0]   level,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full
);
    localparam int PW = AddrWidth + 1;

    if (AddrWidth < 2 || AddrWidth > 16) begin : g_bad_addr_width
        $error("gray_fifo_ctrl: AddrWidth out of range");
    end
    if (AlmostFullThresh < 1 || AlmostFullThresh > 2**AddrWidth + 1) begin : g_bad_thresh
        $error("gray_fifo_ctrl: AlmostFullThresh out of range");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;

    // Flags come from registered pointers only, so a read never hits the slot being written.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AddrWidth{1'b0}}});
    assign wr_ready = !full;
    assign rd_valid = (state == VALID);

    // Strobes are masked while rst is high so the RAM sees no traffic during reset.
    assign mem_we    = wr_valid && !full && !rst;
    assign mem_waddr = wr_ptr[AddrWidth-1:0];
    assign mem_re    = !rst && !empty && ((state == IDLE) || rd_ready);
    assign mem_raddr = rd_ptr[AddrWidth-1:0];

    assign wr_ptr_next = wr_ptr + PW'(mem_we);
    assign rd_ptr_next = rd_ptr + PW'(mem_re);

    // Occupancy counts the word parked in the RAM output register as well.
    assign level = (wr_ptr - rd_ptr) + {{AddrWidth{1'b0}}, rd_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_ptr_gray <= '0;
            rd_ptr_gray <= '0;
            state       <= IDLE;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            wr_ptr_gray <= wr_ptr_next ^ (wr_ptr_next >> 1);
            rd_ptr_gray <= rd_ptr_next ^ (rd_ptr_next >> 1);
            case (state)
                IDLE: begin
                    if (mem_re) state <= VALID;
                end
                VALID: begin
                    // Without a refill the consumed word leaves the output register empty.
                    if (mem_re)        state <= VALID;
                    else if (rd_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GRAY_FIFO_CTRL_ALMOST_FULL_EN
    localparam logic [PW-1:0] AfThresh = PW'(AlmostFullThresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) almost_full <= 1'b0;
        else     almost_full <= (level >= AfThresh);
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed bench for gray_fifo_ctrl (AddrWidth=2, AlmostFullThresh=3) with a behavioural RAM and data scoreboard.
module tb_gray_fifo_ctrl;
    localparam int AW = 2;
    localparam int PW = AW + 1;
    localparam int AF_THRESH = 3;
`ifdef GRAY_FIFO_CTRL_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic          rd_valid;
    logic          rd_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [PW-1:0] wr_ptr_gray;
    logic [PW-1:0] rd_ptr_gray;
    logic [PW-1:0] level;
    logic          full;
    logic          empty;
    logic          almost_full;

    gray_fifo_ctrl #(.AddrWidth(AW), .AlmostFullThresh(AF_THRESH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
        .level(level), .full(full), .empty(empty), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: 1-cycle read latency, output register holds while mem_re=0.
    logic [7:0] ram [0:3];
    logic [7:0] rdata;
    logic [7:0] wdata;
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= wdata;
        if (mem_re) rdata <= ram[mem_raddr];
    end

    logic [7:0]    exp_q[$];
    int            checks;
    int            errors;
    int            lvl_now;
    bit            wr_seen;
    bit            re_seen;
    bit            af_exp;
    bit            wrap_w;
    bit            wrap_r;
    int            accepted;
    logic [PW-1:0] wr_cnt;
    logic [PW-1:0] rd_cnt;
    logic [PW-1:0] prev_wg;
    logic [PW-1:0] prev_rg;

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor, called once per cycle after inputs have settled.
    task automatic settle();
        #1;
        lvl_now = exp_q.size();
        check("level", 32'(level), 32'(lvl_now));
        check("almost_full", 32'(almost_full), 32'(af_exp));
        check("wr_gray", 32'(wr_ptr_gray), 32'(gray(wr_cnt)));
        check("rd_gray", 32'(rd_ptr_gray), 32'(gray(rd_cnt)));
        check("wr_gray_step", 32'($countones(wr_ptr_gray ^ prev_wg) <= 1), 32'd1);
        check("rd_gray_step", 32'($countones(rd_ptr_gray ^ prev_rg) <= 1), 32'd1);
        if (prev_wg == 3'b100 && wr_ptr_gray == 3'b000) wrap_w = 1'b1;
        if (prev_rg == 3'b100 && rd_ptr_gray == 3'b000) wrap_r = 1'b1;
        prev_wg = wr_ptr_gray;
        prev_rg = rd_ptr_gray;
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("rd_underflow", 32'd1, 32'd0);
            else check("rd_data", 32'(rdata), 32'(exp_q.pop_front()));
        end
        wr_seen = wr_valid && wr_ready;
        if (wr_seen) exp_q.push_back(wdata);
        re_seen = mem_re;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
        if (wr_seen) begin
            wdata++;
            wr_cnt++;
            accepted++;
        end
        if (re_seen) rd_cnt++;
        af_exp = AF_EN && (lvl_now >= AF_THRESH);
    endtask

    task automatic cycle();
        settle();
        clk_edge();
    endtask

    task automatic drain();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
        check("drain_done", 32'(exp_q.size()), 32'd0);
        rd_ready = 1'b0;
        cycle();
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
        check({tag, "_wr_gray"}, 32'(wr_ptr_gray), 32'd0);
        check({tag, "_rd_gray"}, 32'(rd_ptr_gray), 32'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        wr_cnt  = '0;
        rd_cnt  = '0;
        prev_wg = '0;
        prev_rg = '0;
        af_exp  = 1'b0;
        wr_seen = 1'b0;
        re_seen = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; accepted = 0; lvl_now = 0;
        wrap_w = 1'b0; wrap_r = 1'b0;
        wdata = 8'h10;
        clear_model();
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;

        // Reset, with wr_valid held high to confirm the write strobe is masked.
        #2 rst = 1'b1;
        wr_valid = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rst = 1'b0;
        cycle();

        // Latency: one write into an empty FIFO.
        wr_valid = 1'b1;
        settle();
        check("lat_we", 32'(mem_we), 32'd1);
        check("lat_waddr", 32'(mem_waddr), 32'd0);
        check("lat_re0", 32'(mem_re), 32'd0);
        clk_edge();
        wr_valid = 1'b0;
        settle();
        check("lat_re1", 32'(mem_re), 32'd1);
        check("lat_raddr", 32'(mem_raddr), 32'd0);
        check("lat_rv1", 32'(rd_valid), 32'd0);
        clk_edge();
        settle();
        check("lat_rv2", 32'(rd_valid), 32'd1);
        clk_edge();
        drain();

        // Fill: six cycles of writes with no reads.
        accepted = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        settle();
        check("fill_full", 32'(full), 32'd1);
        check("fill_wr_ready", 32'(wr_ready), 32'd0);
        check("fill_we_blocked", 32'(mem_we), 32'd0);
        check("fill_level", 32'(level), 32'd5);
        clk_edge();
        check("fill_accepted", 32'(accepted), 32'd5);
        drain();

        // Streaming: simultaneous writes and reads for 40 cycles.
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        drain();
        check("wrap_wr_gray", 32'(wrap_w), 32'd1);
        check("wrap_rd_gray", 32'(wrap_r), 32'd1);

        // Back-pressure: rd_ready 1,0,0,1 while data is waiting.
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        wr_valid = 1'b0;
        cycle();
        foreach (exp_q[i]) if (i == 0) check("bp_rv", 32'(rd_valid), 32'd1);
        for (int s = 0; s < 4; s++) begin
            rd_ready = (s == 0 || s == 3);
            settle();
            if (!rd_ready) begin
                check("bp_no_re", 32'(mem_re), 32'd0);
                check("bp_rv_hold", 32'(rd_valid), 32'd1);
                check("bp_data_stable", 32'(rdata), 32'(exp_q[0]));
            end
            clk_edge();
        end
        drain();

        // Almost-full: climb past the threshold, then consume two words.
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        wr_valid = 1'b0;
        cycle();
        cycle();
        rd_ready = 1'b1;
        cycle();
        cycle();
        rd_ready = 1'b0;
        cycle();
        cycle();
        drain();

        // Reset mid-operation with three words held.
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        wr_valid = 1'b0;
        settle();
        check("pre_rst_level", 32'(level), 32'd3);
        clk_edge();
        #2;
        rst = 1'b1;
        wr_valid = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        clear_model();
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rst = 1'b0;
        cycle();
        wr_valid = 1'b1;
        cycle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
